array_36_ctrl: RTL and testbench

ARRAY_36_CTRL -- requirements
Module: array_36_ctrl

---
 rtl/array_36_pkg.sv | 25 ++
 rtl/array_36_arb.sv | 53 +++++
 rtl/array_36_ctrl.sv | 133 +++++++++++++
 tb/tb_array_36_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/array_36_pkg.sv
// Shared constants and FSM encoding for the array_36 clear/arbitration controller.
package array_36_pkg;

   // Geometry of the 4096x40 masked single-port SRAM
   localparam int DEPTH        = 4096;
   localparam int ADDR_W       = 12;
   localparam int DATA_W       = 40;
   localparam int MASK_W       = 8;
   localparam int SEG_W        = DATA_W / MASK_W;

   // Consecutive read losses tolerated before the read side is forced to win
   localparam int STARVE_LIMIT = 4;

   // INIT sweeps zeros through the whole array; RUN serves requests
   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Width of a counter that must hold values 0..limit inclusive
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/array_36_arb.sv
// Single-slot read/write arbiter: write wins by default, a read that has lost
// STARVE_LIMIT cycles in a row wins the next contested cycle.
module array_36_arb
   import array_36_pkg::*;
#(
   parameter int STARVE_LIMIT = array_36_pkg::STARVE_LIMIT
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   input  logic r_valid,
   input  logic w_valid,
   output logic r_grant,
   output logic w_grant
);

   localparam int CNT_W = cnt_width(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;
   logic             starved;

   assign starved = (starve_cnt == LIMIT);

   // Grant decision: at most one winner per cycle, nothing granted outside RUN
   always_comb begin
      // NOTE: every output gets a default before any branch so no path can leave
      // it unassigned, which would otherwise infer a latch.
      r_grant = 1'b0;
      w_grant = 1'b0;
      if (run) begin
         if (r_valid && (starved || !w_valid)) begin
            r_grant = 1'b1;
         end else if (w_valid) begin
            w_grant = 1'b1;
         end
      end
   end

   // Starvation counter: counts read losses in RUN, saturating at the limit
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: state updates use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (reset) begin
         starve_cnt <= '0;
      end else if (!run || !r_valid || r_grant) begin
         starve_cnt <= '0;
      end else if (!starved) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/array_36_ctrl.sv
// Front-end controller for a 4096x40 masked single-port SRAM: zero-fills the
// array after reset or flush, then arbitrates read and masked-write requests
// onto the one RW port and returns read data with a fixed one-cycle latency.
module array_36_ctrl #(
   parameter int DEPTH        = array_36_pkg::DEPTH,
   parameter int ADDR_W       = array_36_pkg::ADDR_W,
   parameter int DATA_W       = array_36_pkg::DATA_W,
   parameter int MASK_W       = array_36_pkg::MASK_W,
   parameter int STARVE_LIMIT = array_36_pkg::STARVE_LIMIT
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              r_valid,
   output logic              r_ready,
   input  logic [ADDR_W-1:0] r_addr,

   output logic              r_resp_valid,
   output logic [DATA_W-1:0] r_resp_data,

   input  logic              w_valid,
   output logic              w_ready,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [MASK_W-1:0] w_mask,
   input  logic [DATA_W-1:0] w_data,

   input  logic              flush,
   output logic              init_done,

   output logic              sram_en,
   output logic              sram_wmode,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [MASK_W-1:0] sram_wmask,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   import array_36_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e            state;
   logic [ADDR_W-1:0] clr_cnt;
   logic              run;
   logic              r_grant;
   logic              w_grant;
   logic              resp_q;

   assign run       = (state == ST_RUN);
   assign init_done = run;
   assign r_ready   = r_grant;
   assign w_ready   = w_grant;

   array_36_arb #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clock   (clock),
      .reset   (reset),
      .run     (run),
      .r_valid (r_valid),
      .w_valid (w_valid),
      .r_grant (r_grant),
      .w_grant (w_grant)
   );

   // FSM and clear counter: INIT walks 0..DEPTH-1 then enters RUN; flush in RUN restarts the sweep
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: the SRAM array itself has no reset pin; its contents are only
      // made defined by the INIT sweep below, never by the flop reset.
      if (reset) begin
         state   <= ST_INIT;
         clr_cnt <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               if (clr_cnt == LAST_ADDR) begin
                  state   <= ST_RUN;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + ADDR_W'(1);
               end
            end
            ST_RUN: begin
               if (flush) begin
                  state   <= ST_INIT;
                  clr_cnt <= '0;
               end
            end
            default: begin
               state   <= ST_INIT;
               clr_cnt <= '0;
            end
         endcase
      end
   end

   // Response pipeline: a read granted this cycle returns its data next cycle, even across a flush
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resp_q <= 1'b0;
      end else begin
         resp_q <= r_grant;
      end
   end

   assign r_resp_valid = resp_q;
   assign r_resp_data  = resp_q ? sram_rdata : '0;

   // SRAM port mux: clear write in INIT, granted request in RUN, idle otherwise
   always_comb begin
      sram_en    = 1'b0;
      sram_wmode = 1'b0;
      sram_addr  = '0;
      sram_wmask = '0;
      sram_wdata = '0;
      if (!run) begin
         sram_en    = 1'b1;
         sram_wmode = 1'b1;
         sram_addr  = clr_cnt;
         sram_wmask = '1;
      end else if (r_grant) begin
         sram_en    = 1'b1;
         sram_addr  = r_addr;
      end else if (w_grant) begin
         sram_en    = 1'b1;
         sram_wmode = 1'b1;
         sram_addr  = w_addr;
         sram_wmask = w_mask;
         sram_wdata = w_data;
      end
   end

endmodule

// File: tb/tb_array_36_ctrl.sv
// Directed bench for array_36_ctrl with a behavioural masked SRAM and a
// read-response scoreboard checked by an independent monitor.
module tb_array_36_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        r_valid;
   logic        r_ready;
   logic [11:0] r_addr;
   logic        r_resp_valid;
   logic [39:0] r_resp_data;
   logic        w_valid;
   logic        w_ready;
   logic [11:0] w_addr;
   logic [7:0]  w_mask;
   logic [39:0] w_data;
   logic        flush;
   logic        init_done;
   logic        sram_en;
   logic        sram_wmode;
   logic [11:0] sram_addr;
   logic [7:0]  sram_wmask;
   logic [39:0] sram_wdata;
   logic [39:0] sram_rdata;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      logic [39:0] data;
      int          due;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   logic [39:0] mem [4096];

   array_36_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .r_valid      (r_valid),
      .r_ready      (r_ready),
      .r_addr       (r_addr),
      .r_resp_valid (r_resp_valid),
      .r_resp_data  (r_resp_data),
      .w_valid      (w_valid),
      .w_ready      (w_ready),
      .w_addr       (w_addr),
      .w_mask       (w_mask),
      .w_data       (w_data),
      .flush        (flush),
      .init_done    (init_done),
      .sram_en      (sram_en),
      .sram_wmode   (sram_wmode),
      .sram_addr    (sram_addr),
      .sram_wmask   (sram_wmask),
      .sram_wdata   (sram_wdata),
      .sram_rdata   (sram_rdata)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural SRAM: 8 mask segments of 5 bits, registered read
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = {8'hA5, $urandom()};
      sram_rdata = 40'h0;
   end

   always @(posedge clock) begin
      if (sram_en === 1'b1) begin
         if (sram_wmode === 1'b1) begin
            for (int s = 0; s < 8; s++)
               if (sram_wmask[s]) mem[sram_addr][s*5 +: 5] <= sram_wdata[s*5 +: 5];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every response must match the oldest expected entry and arrive on its due cycle
   always @(negedge clock) begin
      if (r_resp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_unexpected: got data 0x%0h with nothing outstanding (cycle %0d)", r_resp_data, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            check("resp_data", r_resp_data, mon_e.data);
            check("resp_latency", cyc, mon_e.due);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Checks n clear-write cycles starting at address 0; raises flush during cycle flush_at+1
   task automatic check_clear(input int n, input int flush_at);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         check("clr_sram_ctl", {sram_en, sram_wmode, sram_addr, sram_wmask},
               {1'b1, 1'b1, 12'(i), 8'hFF});
         check("clr_data_ready", {sram_wdata, r_ready, w_ready, init_done}, 43'h0);
         @(posedge clock); #1;
         flush = (i == flush_at);
      end
      flush = 1'b0;
   endtask

   task automatic check_run_idle();
      @(negedge clock);
      check("init_done_run", init_done, 1'b1);
      check("idle_sram", {sram_en, sram_wmask, sram_wdata, r_ready, w_ready}, 51'h0);
      @(posedge clock); #1;
   endtask

   task automatic do_write(input logic [11:0] addr, input logic [7:0] mask, input logic [39:0] data);
      bit got = 1'b0;
      w_valid = 1'b1; w_addr = addr; w_mask = mask; w_data = data;
      for (int k = 0; k < 16 && !got; k++) begin
         @(negedge clock);
         if (w_ready === 1'b1) begin
            got = 1'b1;
            check("wr_sram_ctl", {sram_en, sram_wmode, sram_addr, sram_wmask}, {1'b1, 1'b1, addr, mask});
            check("wr_sram_data", sram_wdata, data);
         end
         @(posedge clock); #1;
      end
      w_valid = 1'b0; w_mask = 8'h0; w_data = 40'h0;
      if (!got) begin
         n_checks++; n_errors++;
         $display("FAIL wr_timeout: addr 0x%0h never granted", addr);
      end
   endtask

   task automatic do_read(input logic [11:0] addr, input logic [39:0] exp);
      bit got = 1'b0;
      r_valid = 1'b1; r_addr = addr;
      for (int k = 0; k < 16 && !got; k++) begin
         @(negedge clock);
         if (r_ready === 1'b1) begin
            got = 1'b1;
            sb_q.push_back('{exp, cyc + 1});
            check("rd_sram_ctl", {sram_en, sram_wmode, sram_addr}, {1'b1, 1'b0, addr});
            check("rd_no_wdata", {sram_wmask, sram_wdata}, 48'h0);
         end
         @(posedge clock); #1;
      end
      r_valid = 1'b0;
      if (!got) begin
         n_checks++; n_errors++;
         $display("FAIL rd_timeout: addr 0x%0h never granted", addr);
      end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      r_valid = 1'b0; r_addr = 12'h0;
      w_valid = 1'b0; w_addr = 12'h0; w_mask = 8'h0; w_data = 40'h0;

      @(negedge clock);
      check("reset_state", {init_done, r_resp_valid, r_ready, w_ready}, 4'h0);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;

      // Full clear after reset, with a flush pulse mid-sweep that must be ignored
      check_clear(4096, 100);
      check_run_idle();

      // Cleared contents read back as zero
      do_read(12'h123, 40'h0);

      // Masked writes: only segment 0 (bits 4:0) lands
      do_write(12'd5, 8'h01, 40'h00_0000_001F);
      do_read(12'd5, 40'h00_0000_001F);
      do_write(12'd6, 8'h01, 40'hFF_FFFF_FFFF);
      do_read(12'd6, 40'h00_0000_001F);

      // Read the cycle right after a full-mask write to the same address
      do_write(12'd7, 8'hFF, 40'hAB_CDEF_0123);
      do_read(12'd7, 40'hAB_CDEF_0123);

      // Both sides saturated: four writes, then the starved read, repeating
      r_valid = 1'b1; r_addr = 12'h123;
      w_valid = 1'b1; w_addr = 12'h200; w_mask = 8'hFF; w_data = 40'h55;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("arb_r_ready", r_ready, (i % 5) == 4);
         check("arb_w_ready", w_ready, (i % 5) != 4);
         if ((i % 5) == 4) sb_q.push_back('{40'h0, cyc + 1});
         @(posedge clock); #1;
      end
      r_valid = 1'b0; w_valid = 1'b0; w_mask = 8'h0; w_data = 40'h0;
      do_read(12'h200, 40'h55);

      // Flush coincident with a read grant: response still delivered, then a full clear
      do_write(12'd3, 8'hFF, 40'h12_3456_789A);
      r_valid = 1'b1; r_addr = 12'd3; flush = 1'b1;
      @(negedge clock);
      check("flush_rd_grant", r_ready, 1'b1);
      sb_q.push_back('{40'h12_3456_789A, cyc + 1});
      @(posedge clock); #1;
      r_valid = 1'b0; flush = 1'b0;
      check_clear(4096, -1);
      check_run_idle();
      do_read(12'd3, 40'h0);
      do_read(12'd7, 40'h0);

      // Reset with a read in flight: the response must be dropped
      r_valid = 1'b1; r_addr = 12'd1;
      @(negedge clock);
      check("rst_rd_grant", r_ready, 1'b1);
      #1;
      reset = 1'b1; r_valid = 1'b0;
      #1;
      check("rst_async", {init_done, r_resp_valid}, 2'b00);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;

      // Reset at clear counter 2000 restarts the sweep from address 0
      check_clear(2000, -1);
      reset = 1'b1;
      #1;
      check("rst_mid_init", {init_done, r_resp_valid, sram_addr}, 14'h0);
      @(posedge clock); #1;
      reset = 1'b0;
      check_clear(4096, -1);
      check_run_idle();
      do_write(12'd9, 8'h80, 40'hFF_FFFF_FFFF);
      do_read(12'd9, 40'hF8_0000_0000);

      repeat (3) @(posedge clock);
      #1;
      check("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
